// File: rtl/imem_loader_if.sv
// Word-stream handshake between the host/UART source and the instruction-memory loader.
interface imem_loader_if;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: splits 32-bit stream words into little-endian byte writes from address 0
// and holds the CPU in reset until the whole session has been written.
module imem_loader #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned MAX_WORDS     = 256,
   parameter int unsigned CNT_WIDTH     = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [CNT_WIDTH-1:0]     word_count,
   imem_loader_if.slave             s_if,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     cpu_hold,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACCEPT = 3'd1;
   localparam logic [2:0] S_WRITE  = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_ERROR  = 3'd4;

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WORDS);

   logic [2:0]               r_state;
   logic [2:0]               w_state_next;
   logic [CNT_WIDTH-1:0]     r_count;
   logic [CNT_WIDTH-1:0]     r_word_idx;
   logic [1:0]               r_byte_idx;
   logic [31:0]              r_word;
   logic [ADDRESS_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0]    r_mem_wdata;

   logic       w_count_ok;
   logic       w_can_start;
   logic       w_load;
   logic       w_accept;
   logic       w_write;
   logic       w_last_word;
   logic [1:0] w_byte_next;

   assign w_count_ok  = (word_count != '0) && (word_count <= MAX_CNT);
   // start is only honoured while no session is running
   assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
   assign w_load      = w_can_start && start && w_count_ok;
   assign w_accept    = (r_state == S_ACCEPT) && s_if.s_valid;
   assign w_write     = (r_state == S_WRITE);
   assign w_last_word = (r_word_idx == r_count - CNT_WIDTH'(1));
   assign w_byte_next = r_byte_idx + 2'd1;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) w_state_next = w_count_ok ? S_ACCEPT : S_ERROR;
         end
         S_ACCEPT: begin
            if (s_if.s_valid) w_state_next = S_WRITE;
         end
         S_WRITE: begin
            if (r_byte_idx == 2'd3) w_state_next = w_last_word ? S_DONE : S_ACCEPT;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_word_idx  <= '0;
         r_byte_idx  <= '0;
         r_word      <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_load) begin
            r_count    <= word_count;
            r_word_idx <= '0;
         end
         // Address/data are registered one byte ahead so they hold once mem_we drops
         if (w_accept) begin
            r_word      <= s_if.s_data;
            r_byte_idx  <= 2'd0;
            r_mem_addr  <= ADDRESS_WIDTH'({r_word_idx, 2'b00});
            r_mem_wdata <= s_if.s_data[7:0];
         end
         if (w_write) begin
            if (r_byte_idx != 2'd3) begin
               r_byte_idx  <= w_byte_next;
               r_mem_addr  <= r_mem_addr + ADDRESS_WIDTH'(1);
               r_mem_wdata <= r_word[{w_byte_next, 3'b000} +: 8];
            end else if (!w_last_word) begin
               r_word_idx <= r_word_idx + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign s_if.s_ready = (r_state == S_ACCEPT);
   assign mem_we       = w_write;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign cpu_hold     = (r_state != S_DONE);
   assign busy         = (r_state == S_ACCEPT) || (r_state == S_WRITE);
   assign done         = (r_state == S_DONE);
   assign err          = (r_state == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: session table plus a write scoreboard fed at each handshake.
module tb_imem_loader;

   localparam int CNT_W = 9;

   typedef struct {
      logic [CNT_W-1:0] count;
      logic [2:0][31:0] words;
      int               gap;
      bit               noise;
      bit               exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] word_count;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [7:0]       mem_wdata;
   logic             cpu_hold;
   logic             busy;
   logic             done;
   logic             err;

   imem_loader_if sif ();

   imem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .word_count (word_count),
      .s_if       (sif),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   wr_t  sb[$];
   wr_t  mon_e;
   vec_t vecs[7];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every write must match the oldest expected byte, and s_ready must be low while writing
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         if (sb.size() == 0) begin
            chk("spurious mem_we", 32'(mem_we), 0);
         end else begin
            mon_e = sb.pop_front();
            chk("write addr", mem_addr, mon_e.addr);
            chk("write data", 32'(mem_wdata), 32'(mon_e.data));
            chk("s_ready during WRITE", 32'(sif.s_ready), 0);
            chk("cpu_hold during WRITE", 32'(cpu_hold), 1);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic do_start(input logic [CNT_W-1:0] cnt, input bit exp_err);
      start = 1'b1;
      word_count = cnt;
      @(posedge clk); #1;
      start = 1'b0;
      word_count = $urandom_range(0, 511);
      chk("err after start", 32'(err), exp_err ? 1 : 0);
      chk("cpu_hold after start", 32'(cpu_hold), 1);
      chk("done after start", 32'(done), 0);
      chk("busy after start", 32'(busy), exp_err ? 0 : 1);
      chk("s_ready after start", 32'(sif.s_ready), exp_err ? 0 : 1);
   endtask

   task automatic send_word(input int idx, input logic [31:0] w, input bit noise);
      start = 1'b0;
      sif.s_valid = 1'b1;
      sif.s_data = w;
      chk("s_ready at handshake", 32'(sif.s_ready), 1);
      for (int b = 0; b < 4; b++) sb.push_back('{addr: 32'(idx * 4 + b), data: w[8*b +: 8]});
      @(posedge clk); #1;
      sif.s_valid = noise;
      sif.s_data = $urandom;
      if (noise) begin
         start = 1'b1;
         word_count = 9'd7;
      end
   endtask

   // Handshake edge was E0; return just after E4, clearing any noise after E3
   task automatic finish_write();
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      sif.s_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] w;
      logic [31:0] last_w;
      last_w = '0;
      do_start(v.count, v.exp_err);
      if (v.exp_err) begin
         repeat (3) @(posedge clk);
         #1;
         chk("err held", 32'(err), 1);
         chk("cpu_hold in ERROR", 32'(cpu_hold), 1);
         chk("no write in ERROR", 32'(mem_we), 0);
      end else begin
         for (int i = 0; i < int'(v.count); i++) begin
            if (i > 0) begin
               for (int g = 0; g < v.gap; g++) begin
                  @(posedge clk); #1;
                  start = v.noise && (g == 0);
                  word_count = 9'd1;
                  chk("mem_we in gap", 32'(mem_we), 0);
                  chk("s_ready in gap", 32'(sif.s_ready), 1);
               end
            end
            w = (i < 3) ? v.words[i] : $urandom;
            send_word(i, w, v.noise);
            finish_write();
            last_w = w;
         end
         chk("done after last write", 32'(done), 1);
         chk("cpu_hold released", 32'(cpu_hold), 0);
         chk("busy in DONE", 32'(busy), 0);
         chk("s_ready in DONE", 32'(sif.s_ready), 0);
         chk("scoreboard drained", 32'(sb.size()), 0);
         repeat (2) @(posedge clk);
         #1;
         chk("done held", 32'(done), 1);
         chk("mem_addr hold", mem_addr, 32'((int'(v.count) - 1) * 4 + 3));
         chk("mem_wdata hold", 32'(mem_wdata), 32'(last_w[31:24]));
      end
   endtask

   initial begin
      vecs[0] = '{count: 9'd2,   words: {32'h0, 32'h00000513, 32'h0ff00313}, gap: 0, noise: 0, exp_err: 0};
      vecs[1] = '{count: 9'd3,   words: {32'ha5c30f96, 32'h12345678, 32'hdeadbeef}, gap: 7, noise: 1, exp_err: 0};
      vecs[2] = '{count: 9'd0,   words: '0, gap: 0, noise: 0, exp_err: 1};
      vecs[3] = '{count: 9'd257, words: '0, gap: 0, noise: 0, exp_err: 1};
      vecs[4] = '{count: 9'd1,   words: {32'h0, 32'h0, 32'hcafef00d}, gap: 0, noise: 0, exp_err: 0};
      vecs[5] = '{count: 9'd256, words: {32'h00300193, 32'h00200113, 32'h00100093}, gap: 0, noise: 0, exp_err: 0};
      vecs[6] = '{count: 9'd1,   words: {32'h0, 32'h0, 32'h00008067}, gap: 0, noise: 0, exp_err: 0};

      rst = 1'b1;
      start = 1'b0;
      word_count = '0;
      sif.s_valid = 1'b0;
      sif.s_data = '0;
      #2;
      chk("reset cpu_hold", 32'(cpu_hold), 1);
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      chk("reset err", 32'(err), 0);
      chk("reset mem_we", 32'(mem_we), 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset s_ready", 32'(sif.s_ready), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("idle cpu_hold", 32'(cpu_hold), 1);
      chk("idle s_ready", 32'(sif.s_ready), 0);

      for (int k = 0; k < 6; k++) run_vec(vecs[k]);

      // Reset while byte 2 of word 1 is on the bus
      do_start(9'd2, 0);
      send_word(0, 32'h00500113, 0);
      finish_write();
      send_word(1, 32'h00a00193, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre-reset mem_we", 32'(mem_we), 1);
      chk("pre-reset mem_addr", mem_addr, 6);
      #2 rst = 1'b1;
      #1;
      chk("async rst mem_we", 32'(mem_we), 0);
      chk("async rst mem_addr", mem_addr, 0);
      chk("async rst mem_wdata", 32'(mem_wdata), 0);
      chk("async rst cpu_hold", 32'(cpu_hold), 1);
      chk("async rst busy", 32'(busy), 0);
      chk("async rst s_ready", 32'(sif.s_ready), 0);
      sb.delete();
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      chk("post-reset busy", 32'(busy), 0);
      chk("post-reset cpu_hold", 32'(cpu_hold), 1);
      chk("post-reset mem_we", 32'(mem_we), 0);
      run_vec(vecs[6]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
